// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder reused for WIDTH cycles, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;
  logic             accept, step, flush, last;

  full_adder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!abort && in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      overflow  <= 1'b0;
`endif
    end else if (flush) begin
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      overflow  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= sub ? ~b : b;
      carry  <= sub;
      cnt    <= '0;
      result <= '0;
    end else if (step) begin
      // Sum bits enter at the MSB so bit 0 lands at result[0] after WIDTH steps.
      result <= {fa_s, result[WIDTH-1:1]};
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        carry_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        overflow  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8); overflow checks follow SERIAL_ADD_OVF_EN.

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk, rst_n, in_valid, in_ready, sub, abort, busy, out_valid, out_ready, carry_out;
  logic [W-1:0] a, b, result;
`ifdef SERIAL_ADD_OVF_EN
  logic         overflow;
`endif

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1);
  end

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(ma);
    ub = longint'(mb);
    us = ms ? (ua + ((longint'(1) << W) - 1 - ub) + 1) : (ua + ub);
    c  = (us >= (longint'(1) << W));
    sa = (ua >= (longint'(1) << (W - 1))) ? ua - (longint'(1) << W) : ua;
    sb = (ub >= (longint'(1) << (W - 1))) ? ub - (longint'(1) << W) : ub;
    ss = ms ? sa - sb : sa + sb;
    v  = (ss > ((longint'(1) << (W - 1)) - 1)) || (ss < -(longint'(1) << (W - 1)));
    r  = W'(us);
  endfunction

  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os);
    a = oa; b = ob; sub = os; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (out_valid !== 1'b1 && lat < 4 * W) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if ({in_ready, busy, out_valid, carry_out} !== 4'b1000 || result !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got rdy=%b busy=%b ov=%b co=%b res=%h expected 1 0 0 0 00",
                 i, in_ready, busy, out_valid, carry_out, result);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_latency();
    int lat, bcnt;
    start_op(8'h3C, 8'h5A, 1'b0);
    wait_done(lat, bcnt);
    n_checks++;
    if (lat != W) begin n_fail++; $display("FAIL latency: got %0d expected %0d", lat, W); end
    n_checks++;
    if (bcnt != W) begin n_fail++; $display("FAIL busy_cycles: got %0d expected %0d", bcnt, W); end
    n_checks++;
    if (result !== 8'h96 || carry_out !== 1'b0) begin
      n_fail++; $display("FAIL add_3c_5a: got %h/%b expected 96/0", result, carry_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL add_3c_5a_ovf: got %b expected 1", overflow); end
`endif
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_flags: got rdy=%b busy=%b expected 0 0", in_ready, busy);
    end
    ack();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h96) begin
      n_fail++; $display("FAIL after_ack: got rdy=%b ov=%b res=%h expected 1 0 96", in_ready, out_valid, result);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[3] = '{8'hFF, 8'h80, 8'h10};
    logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'h20};
    logic         ts[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] er[3] = '{8'h00, 8'h7F, 8'hF0};
    logic         ec[3] = '{1'b1, 1'b1, 1'b0};
    logic         ev[3] = '{1'b0, 1'b1, 1'b0};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_done(lat, bcnt);
      n_checks++;
      if (out_valid !== 1'b1 || result !== er[i] || carry_out !== ec[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b %h/%b expected 1 %h/%b", i, out_valid, result, carry_out, er[i], ec[i]);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (overflow !== ev[i]) begin n_fail++; $display("FAIL directed_ovf[%0d]: got %b expected %b", i, overflow, ev[i]); end
`else
      if (ev[i] === 1'bx) $display("unreachable");
`endif
      ack();
    end
  endtask

  task automatic test_hold_done();
    int lat, bcnt;
    logic [W-1:0] er;
    logic         ec, ev;
    start_op(8'h55, 8'h33, 1'b0);
    wait_done(lat, bcnt);
    a = 8'h0F; b = 8'h0E; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h88 || carry_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_done[%0d]: got v=%b rdy=%b %h/%b expected 1 0 88/0", i, out_valid, in_ready, result, carry_out);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, bcnt);
    model(8'h0F, 8'h0E, 1'b1, er, ec, ev);
    n_checks++;
    if (lat != W || result !== er || carry_out !== ec) begin
      n_fail++; $display("FAIL hold_next_op: got lat=%0d %h/%b expected %0d %h/%b", lat, result, carry_out, W, er, ec);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (overflow !== ev) begin n_fail++; $display("FAIL hold_next_ovf: got %b expected %b", overflow, ev); end
`endif
    ack();
  endtask

  task automatic test_abort();
    int lat, bcnt, seen;
    start_op(8'h3C, 8'h5A, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_run: got rdy=%b busy=%b v=%b %h/%b expected 1 0 0 00/0", in_ready, busy, out_valid, result, carry_out);
    end
    seen = 0;
    repeat (W + 4) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
    a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(lat, bcnt);
    n_checks++;
    if (result !== 8'hFE || carry_out !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort_done: got %h/%b expected fe/1", result, carry_out);
    end
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00 || carry_out !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got v=%b rdy=%b %h/%b expected 0 1 00/0", out_valid, in_ready, result, carry_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_done_ovf: got %b expected 0", overflow); end
`endif
  endtask

  task automatic test_reset_midop();
    int lat, bcnt;
    start_op(8'h3C, 8'h5A, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b busy=%b v=%b %h/%b expected 1 0 0 00/0", in_ready, busy, out_valid, result, carry_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(lat, bcnt);
    n_checks++;
    if (lat != W || result !== 8'h80 || carry_out !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_op: got lat=%0d %h/%b expected %0d 80/0", lat, result, carry_out, W);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL post_reset_ovf: got %b expected 1", overflow); end
`endif
    ack();
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, ev;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      model(ra, rb, rs, er, ec, ev);
      start_op(ra, rb, rs);
      wait_done(lat, bcnt);
      n_checks++;
      if (lat != W || result !== er || carry_out !== ec) begin
        n_fail++;
        $display("FAIL random[%0d] %h %s %h: got lat=%0d %h/%b expected %0d %h/%b",
                 i, ra, rs ? "-" : "+", rb, lat, result, carry_out, W, er, ec);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (overflow !== ev) begin n_fail++; $display("FAIL random_ovf[%0d]: got %b expected %b", i, overflow, ev); end
`endif
      ack();
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_add_latency();
    test_directed();
    test_hold_done();
    test_abort();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
